// File: rtl/pipe_share_arbiter.sv
// pipe_share_arbiter: shares one fixed-latency, non-stallable shift-register
// pipeline between two valid/ready requesters. The granted word is registered
// onto the pipeline input. A per-word owner tag travels alongside the pipeline
// so that each result can be steered back to the requester that issued it.
// The block also sequences a post-reset flush and a drain-to-idle phase.
//
// Build option: define PIPE_SHARE_FIXED_PRIO_EN to make requester 0 always win
// when both requesters are valid. By default the two requesters alternate
// (round-robin).
module pipe_share_arbiter #(
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       PIPE_LATENCY = 4,
  parameter logic [DATA_W-1:0] IDLE_DATA    = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req0_valid,
  input  logic [DATA_W-1:0]                 req0_data,
  output logic                              req0_ready,
  input  logic                              req1_valid,
  input  logic [DATA_W-1:0]                 req1_data,
  output logic                              req1_ready,
  input  logic                              drain_req,
  output logic [DATA_W-1:0]                 pipe_data_in,
  input  logic [DATA_W-1:0]                 pipe_data_out,
  output logic                              rsp0_valid,
  output logic [DATA_W-1:0]                 rsp0_data,
  output logic                              rsp1_valid,
  output logic [DATA_W-1:0]                 rsp1_data,
  output logic [$clog2(PIPE_LATENCY+2)-1:0] inflight,
  output logic                              idle
);

  localparam int unsigned IW = $clog2(PIPE_LATENCY + 2);
  localparam int unsigned FW = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

  localparam logic [1:0] ST_FLUSH   = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_DRAINED = 2'd3;

  logic [1:0]              state_q;
  logic [1:0]              state_d;
  logic [FW-1:0]           flush_cnt_q;
  logic [IW-1:0]           inflight_q;
  logic [PIPE_LATENCY:0]   tag_valid_q;
  logic [PIPE_LATENCY:0]   tag_id_q;
  logic [DATA_W-1:0]       pipe_data_q;

  logic                    arb_en;
  logic                    gnt0;
  logic                    gnt1;
  logic                    accept;
  logic                    win_id;
  logic [DATA_W-1:0]       win_data;
  logic                    rsp_any;
  logic                    rsp_id;

`ifndef PIPE_SHARE_FIXED_PRIO_EN
  logic                    last_grant_q;
`endif

  // Grants are only offered while running and no drain is requested. Reset
  // also masks them, because the state register is not updated until the
  // reset edge.
  assign arb_en = (state_q == ST_RUN) && !drain_req && !reset;

  // Two-requester arbitration: at most one grant per cycle
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (arb_en) begin
`ifdef PIPE_SHARE_FIXED_PRIO_EN
      gnt0 = req0_valid;
      gnt1 = req1_valid && !req0_valid;
`else
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
`endif
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 || gnt1;
  assign win_id     = gnt1;
  assign win_data   = gnt1 ? req1_data : req0_data;

  // The oldest tag describes the word currently on pipe_data_out
  assign rsp_any    = tag_valid_q[PIPE_LATENCY] && !reset;
  assign rsp_id     = tag_id_q[PIPE_LATENCY];
  assign rsp0_valid = rsp_any && !rsp_id;
  assign rsp1_valid = rsp_any && rsp_id;
  assign rsp0_data  = pipe_data_out;
  assign rsp1_data  = pipe_data_out;

  assign pipe_data_in = pipe_data_q;
  assign inflight     = inflight_q;
  assign idle         = (state_q == ST_DRAINED) && !reset;

  // Next-state logic for the flush / run / drain sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FLUSH:   if (flush_cnt_q == FW'(PIPE_LATENCY - 1)) state_d = ST_RUN;
      ST_RUN:     if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN:   if (inflight_q == '0) state_d = ST_DRAINED;
      ST_DRAINED: if (!drain_req) state_d = ST_RUN;
      default:    state_d = ST_FLUSH;
    endcase
  end

  // State register and flush counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FLUSH) flush_cnt_q <= flush_cnt_q + FW'(1);
    end
  end

`ifndef PIPE_SHARE_FIXED_PRIO_EN
  // Round-robin history: records the id of the most recent accept
  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= 1'b1;
    else if (accept) last_grant_q <= win_id;
  end
`endif

  // Issue register plus the owner-tag shift chain, which runs alongside the
  // pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_data_q <= IDLE_DATA;
      tag_valid_q <= '0;
      tag_id_q    <= '0;
    end else begin
      pipe_data_q <= accept ? win_data : IDLE_DATA;
      if (PIPE_LATENCY > 0) begin
        tag_valid_q <= {tag_valid_q[PIPE_LATENCY-1:0], accept};
        tag_id_q    <= {tag_id_q[PIPE_LATENCY-1:0], accept && win_id};
      end
    end
  end

  // In-flight count: up on accept, down on response, no change if both happen
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= '0;
    end else begin
      unique case ({accept, rsp_any})
        2'b10:   inflight_q <= inflight_q + IW'(1);
        2'b01:   inflight_q <= inflight_q - IW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Bench for pipe_share_arbiter. The pipeline is modelled as a delay line.
// A behavioural model predicts readys, responses, issue data, inflight and
// idle on every cycle. Directed sequences with literal expectations pin that
// model, and they are followed by a randomized phase.
`timescale 1ns/1ps
module tb_pipe_share_arbiter;

  localparam int unsigned LAT = 4;
  localparam logic [7:0]  IDLE = 8'h00;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, drain_req = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, idle;
  logic [7:0] pipe_data_in, pipe_data_out, rsp0_data, rsp1_data;
  logic [2:0] inflight;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_share_arbiter #(.DATA_W(8), .PIPE_LATENCY(LAT), .IDLE_DATA(8'h00)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .drain_req(drain_req),
    .pipe_data_in(pipe_data_in), .pipe_data_out(pipe_data_out),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .inflight(inflight), .idle(idle)
  );

  // External pipeline: a LAT-deep delay line
  logic [7:0] line [LAT] = '{default: 8'h00};
  always @(posedge clk) begin
    line[0] <= pipe_data_in;
    for (int i = 1; i < LAT; i++) line[i] <= line[i-1];
  end
  assign pipe_data_out = line[LAT-1];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct { bit id; logic [7:0] data; } rsp_t;
  localparam int M_FLUSH = 0, M_RUN = 1, M_DRAIN = 2, M_DRAINED = 3;

  initial begin
    rsp_t       sched [int];
    int         cyc, m_mode, m_flush, m_inflight;
    bit         m_last, live, run_ok, g0, g1, acc, r_now, e_r0, e_r1;
    logic [7:0] m_pdi, e_data;
    cyc = 0; live = 0; m_mode = M_FLUSH; m_flush = 0; m_inflight = 0; m_last = 1; m_pdi = IDLE;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        sched.delete();
        m_mode = M_FLUSH; m_flush = 0; m_inflight = 0; m_last = 1; m_pdi = IDLE;
        live = 1;
      end else if (live) begin
        run_ok = (m_mode == M_RUN) && !drain_req;
`ifdef PIPE_SHARE_FIXED_PRIO_EN
        g0 = run_ok && req0_valid;
`else
        g0 = run_ok && req0_valid && (!req1_valid || m_last);
`endif
        g1 = run_ok && req1_valid && !g0;
        acc = g0 || g1;
        r_now = sched.exists(cyc);
        e_r0 = r_now && (sched[cyc].id == 1'b0);
        e_r1 = r_now && (sched[cyc].id == 1'b1);

        chk("m_req0_ready", req0_ready, g0);
        chk("m_req1_ready", req1_ready, g1);
        chk("m_rsp0_valid", rsp0_valid, e_r0);
        chk("m_rsp1_valid", rsp1_valid, e_r1);
        if (e_r0) chk("m_rsp0_data", rsp0_data, sched[cyc].data);
        if (e_r1) chk("m_rsp1_data", rsp1_data, sched[cyc].data);
        chk("m_pipe_data_in", pipe_data_in, m_pdi);
        chk("m_inflight", inflight, m_inflight);
        chk("m_inflight_bound", (inflight <= LAT + 1), 1);
        chk("m_idle", idle, (m_mode == M_DRAINED));

        // advance the model to the next cycle
        if (r_now) sched.delete(cyc);
        if (acc) begin
          e_data = g1 ? req1_data : req0_data;
          sched[cyc + 1 + LAT] = '{id: g1, data: e_data};
          m_pdi = e_data;
          m_last = g1;
        end else begin
          m_pdi = IDLE;
        end
        case (m_mode)
          M_FLUSH:   begin m_flush++; if (m_flush == LAT) m_mode = M_RUN; end
          M_RUN:     if (drain_req) m_mode = M_DRAIN;
          M_DRAIN:   if (m_inflight == 0) m_mode = M_DRAINED;
          default:   if (!drain_req) m_mode = M_RUN;
        endcase
        m_inflight = m_inflight + (acc ? 1 : 0) - (r_now ? 1 : 0);
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit rst, input bit v0, input logic [7:0] d0,
                       input bit v1, input logic [7:0] d1, input bit dr);
    @(negedge clk);
    reset = rst; req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1; drain_req = dr;
    #3;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen0, seen1, got_idle, drn;
    // 1/2: reset, FLUSH for 4 cycles, then 8'hCC accepted and returned 4 later
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 8'hCC, 0, 0, 0);
      chk("flush_ready0_low", req0_ready, 0);
      chk("flush_pdi_idle", pipe_data_in, 8'h00);
    end
    drive(0, 1, 8'hCC, 0, 0, 0);
    chk("first_accept", req0_ready, 1);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk("cc_not_yet", rsp0_valid, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("cc_rsp0_valid", rsp0_valid, 1);
    chk("cc_rsp0_data", rsp0_data, 8'hCC);
    chk("cc_rsp1_quiet", rsp1_valid, 0);

    // 3: both valid continuously
    for (int k = 0; k < 12; k++) begin
      drive(0, 1, 8'hAA, 1, 8'h55, 0);
`ifndef PIPE_SHARE_FIXED_PRIO_EN
      chk("rr_ready1", req1_ready, (k % 2 == 0));
      chk("rr_ready0", req0_ready, (k % 2 == 1));
      if (k >= 5) begin
        chk("rr_rsp1", rsp1_valid, ((k - 5) % 2 == 0));
        chk("rr_rsp0", rsp0_valid, ((k - 5) % 2 == 1));
      end
`endif
      if (k >= 5) chk("rr_inflight5", inflight, 5);
    end
    for (int k = 0; k < 8; k++) drive(0, 0, 0, 0, 0, 0);

    // 4: issue F0 and 0F, then drain to idle, then resume
    drive(0, 1, 8'hF0, 0, 0, 0);
    chk("f0_accept", req0_ready, 1);
    drive(0, 0, 0, 1, 8'h0F, 0);
    chk("0f_accept", req1_ready, 1);
    seen0 = 0; seen1 = 0; got_idle = 0;
    for (int n = 0; n < 20 && !got_idle; n++) begin
      drive(0, 1, 8'h11, 1, 8'h22, 1);
      chk("drain_ready0", req0_ready, 0);
      chk("drain_ready1", req1_ready, 0);
      if (rsp0_valid && rsp0_data == 8'hF0) seen0 = 1;
      if (rsp1_valid && rsp1_data == 8'h0F) seen1 = 1;
      if (idle) begin
        got_idle = 1;
        chk("idle_inflight0", inflight, 0);
      end
    end
    chk("drain_idle_reached", got_idle, 1);
    chk("drain_f0_returned", seen0, 1);
    chk("drain_0f_returned", seen1, 1);
    drive(0, 1, 8'h33, 0, 0, 0);
    chk("drained_no_accept", req0_ready, 0);
    drive(0, 1, 8'h33, 0, 0, 0);
    chk("resume_accept", req0_ready, 1);

    // 5: reset with 3 words in flight discards them
    drive(0, 1, 8'h44, 1, 8'h66, 0);
    drive(0, 1, 8'h44, 1, 8'h66, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("pre_reset_inflight", inflight, 3);
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      drive(0, 1, 8'h77, 0, 0, 0);
      if (k == 0) begin
        chk("post_reset_inflight", inflight, 0);
        chk("post_reset_pdi", pipe_data_in, 8'h00);
      end
      chk("post_reset_rsp0", rsp0_valid, 0);
      chk("post_reset_rsp1", rsp1_valid, 0);
      chk("post_reset_flush", req0_ready, (k >= 4));
    end

`ifdef PIPE_SHARE_FIXED_PRIO_EN
    // 6: fixed priority starves requester 1
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 8'h5A, 1, 8'hA5, 0);
      chk("fixed_ready0", req0_ready, 1);
      chk("fixed_ready1", req1_ready, 0);
    end
`endif

    // randomized phase, checked by the model every cycle
    drn = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 4) drn = !drn;
      drive(($urandom_range(0, 499) == 0),
            ($urandom_range(0, 9) < 6), 8'($urandom),
            ($urandom_range(0, 9) < 6), 8'($urandom), drn);
    end
    for (int k = 0; k < 12; k++) drive(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
